// File: rtl/pll_pkg.sv
// Shared definitions for the EHXPLLL dynamic phase-shift sequencer.
package pll_pkg;

  localparam logic [1:0] CH_CLKOS  = 2'd0;
  localparam logic [1:0] CH_CLKOS2 = 2'd1;
  localparam logic [1:0] CH_CLKOS3 = 2'd2;
  localparam logic [1:0] CH_CLKOP  = 2'd3;

  localparam int unsigned DEF_PULSE_CYC  = 4;
  localparam int unsigned DEF_SETTLE_CYC = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_DONE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous status inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP on an ECP5 EHXPLLL and tracks
// per-channel phase position modulo PHASE_MOD.
module pll_phase_ctrl
  import pll_pkg::*;
#(
  parameter  int unsigned CHANNELS   = 4,
  parameter  int unsigned STEP_W     = 8,
  parameter  int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter  int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter  int unsigned PHASE_MOD  = 24,
  localparam int unsigned POS_W      = (PHASE_MOD > 1) ? $clog2(PHASE_MOD) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      pll_locked,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_chan,
  input  logic                      req_dir,
  input  logic [STEP_W-1:0]         req_steps,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      locked_sync,
  output logic [1:0]                phasesel,
  output logic                      phasedir,
  output logic                      phasestep,
  output logic [CHANNELS*POS_W-1:0] pos
);

  localparam int unsigned CNT_W = $clog2(max_u(PULSE_CYC, SETTLE_CYC) + 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [POS_W:0]   MOD_W     = (POS_W + 1)'(PHASE_MOD);

  state_e              state_q, state_d;
  logic [1:0]          chan_q, chan_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          sel_q, sel_d;
  logic                pdir_q, pdir_d;
  logic [POS_W-1:0]    pos_q [CHANNELS];
  logic [POS_W-1:0]    pos_d [CHANNELS];
  logic                chan_ok;

  sync_2ff u_lock_sync (
    .clk    (clock),
    .rst_n  (reset_n),
    .async_i(pll_locked),
    .sync_o (locked_sync)
  );

  // One extra bit of headroom so +1 never overflows before the wrap compare.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic up);
    logic [POS_W:0] w;
    if (up) begin
      w = {1'b0, p} + (POS_W + 1)'(1);
      if (w >= MOD_W) w = '0;
    end else if (p == '0) begin
      w = MOD_W - (POS_W + 1)'(1);
    end else begin
      w = {1'b0, p} - (POS_W + 1)'(1);
    end
    return w[POS_W-1:0];
  endfunction

  assign chan_ok = ({1'b0, req_chan} < 3'(CHANNELS));

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sel_d   = sel_q;
    pdir_d  = pdir_q;
    pos_d   = pos_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && locked_sync) begin
          chan_d = req_chan;
          dir_d  = req_dir;
          rem_d  = req_steps;
          err_d  = !chan_ok;
          state_d = (!chan_ok || req_steps == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        sel_d   = chan_q;
        pdir_d  = dir_q;
        cnt_d   = PULSE_LD;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d = SETTLE_LD;
          rem_d = rem_q - STEP_W'(1);
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (i == 32'(chan_q)) pos_d[i] = step_pos(pos_q[i], dir_q);
          end
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        // Lock is only sampled here, so a loss never cuts a pulse or settle short.
        if (cnt_q == '0) begin
          if (rem_q == '0) begin
            state_d = ST_DONE;
          end else if (!locked_sync) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            cnt_d   = PULSE_LD;
            state_d = ST_PULSE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_sync) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      pdir_q  <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) pos_q[i] <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      pdir_q  <= pdir_d;
      pos_q   <= pos_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && locked_sync;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign phasestep = (state_q == ST_PULSE);
  assign phasesel  = sel_q;
  assign phasedir  = pdir_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
    assign pos[g*POS_W +: POS_W] = pos_q[g];
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed and random checks of pll_phase_ctrl against a modular-arithmetic position model.
module tb_pll_phase_ctrl;

  localparam int PM = 24;
  localparam int PW = 5;
  localparam int PULSE = 4;
  localparam int SETTLE = 16;

  logic clk = 1'b0;
  logic rst_n, lock;
  logic valid, dir;
  logic [1:0] chan;
  logic [7:0] steps;
  logic ready, busy, done, err, lsync, pdir, pstep;
  logic [1:0] psel;
  logic [4*PW-1:0] pos;

  logic v2, d2;
  logic [1:0] c2;
  logic [7:0] s2;
  logic ready2, busy2, done2, err2, lsync2, pdir2, pstep2;
  logic [1:0] psel2;
  logic [2*PW-1:0] pos2;

  int n_assert = 0;
  int n_fail = 0;
  int mpos[4];

  int pulses = 0, hi_cyc = 0, badw = 0, selbad = 0, run = 0, hi2 = 0;
  logic [1:0] exp_sel = '0;

  always #5 clk = ~clk;

  pll_phase_ctrl dut (
    .clock(clk), .reset_n(rst_n), .pll_locked(lock),
    .req_valid(valid), .req_ready(ready), .req_chan(chan), .req_dir(dir), .req_steps(steps),
    .busy(busy), .done(done), .err(err), .locked_sync(lsync),
    .phasesel(psel), .phasedir(pdir), .phasestep(pstep), .pos(pos)
  );

  pll_phase_ctrl #(.CHANNELS(2)) dut2 (
    .clock(clk), .reset_n(rst_n), .pll_locked(lock),
    .req_valid(v2), .req_ready(ready2), .req_chan(c2), .req_dir(d2), .req_steps(s2),
    .busy(busy2), .done(done2), .err(err2), .locked_sync(lsync2),
    .phasesel(psel2), .phasedir(pdir2), .phasestep(pstep2), .pos(pos2)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (pstep2) hi2++;
      if (pstep) begin
        hi_cyc++;
        run++;
        if (psel !== exp_sel) selbad++;
      end else if (run != 0) begin
        if (run != PULSE) badw++;
        pulses++;
        run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input int ch);
    return int'(pos[ch*PW +: PW]);
  endfunction

  function automatic logic [4*PW-1:0] model_vec();
    logic [4*PW-1:0] v;
    int t;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      t = mpos[i];
      v[i*PW +: PW] = t[PW-1:0];
    end
    return v;
  endfunction

  function automatic int wrap_add(input int p, input int delta);
    return ((p + delta) % PM + PM) % PM;
  endfunction

  task automatic present(input logic [1:0] c, input logic d, input logic [7:0] s);
    int w;
    @(negedge clk);
    valid = 1'b1; chan = c; dir = d; steps = s;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", ready, 1);
  endtask

  // Accept on the next edge, then check latency, pulses and the position model.
  task automatic finish(input logic [1:0] c, input logic d, input logic [7:0] s);
    int lat, p0, h0, b0, sb0, expl;
    exp_sel = c;
    p0 = pulses; h0 = hi_cyc; b0 = badw; sb0 = selbad;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 1;
    while (done !== 1'b1 && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
    end
    expl = (s == 0) ? 1 : 2 + int'(s) * (PULSE + SETTLE);
    chk("latency", lat, expl);
    chk("err_valid_chan", err, 0);
    if (s != 0) begin
      chk("phasesel_at_done", psel, c);
      chk("phasedir_at_done", pdir, d);
    end
    mpos[c] = wrap_add(mpos[c], d ? int'(s) : -int'(s));
    chk("pos_vector", pos, model_vec());
    chk("pulse_count", pulses - p0, s);
    chk("high_cycles", hi_cyc - h0, PULSE * int'(s));
    chk("pulse_width", badw - b0, 0);
    chk("sel_during_pulse", selbad - sb0, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int n, p0;
    logic [1:0] rc;
    logic rd;
    logic [7:0] rs;

    for (int i = 0; i < 4; i++) mpos[i] = 0;
    rst_n = 1'b1; lock = 1'b0;
    valid = 1'b0; chan = '0; dir = 1'b0; steps = '0;
    v2 = 1'b0; c2 = '0; d2 = 1'b0; s2 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_phasesel", psel, 0);
    chk("rst_phasedir", pdir, 0);
    chk("rst_phasestep", pstep, 0);
    chk("rst_pos", pos, 0);
    chk("rst_lsync", lsync, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Lock bring-up combined with the single step on channel 3.
    @(negedge clk);
    valid = 1'b1; chan = 2'd3; dir = 1'b1; steps = 8'd1;
    repeat (5) @(negedge clk);
    chk("no_ready_unlocked", ready, 0);
    chk("no_busy_unlocked", busy, 0);
    lock = 1'b1;
    @(posedge clk); #1;
    chk("ready_edge1", ready, 0);
    @(posedge clk); #1;
    chk("ready_edge2", ready, 1);
    chk("lsync_edge2", lsync, 1);
    finish(2'd3, 1'b1, 8'd1);
    chk("pos3_is_1", pos_of(3), 1);

    present(2'd0, 1'b0, 8'd1);
    finish(2'd0, 1'b0, 8'd1);
    chk("pos0_wrap_down", pos_of(0), PM - 1);
    present(2'd0, 1'b1, 8'd25);
    finish(2'd0, 1'b1, 8'd25);
    chk("pos0_wrap_up", pos_of(0), 0);

    present(2'd1, 1'b1, 8'd0);
    finish(2'd1, 1'b1, 8'd0);

    // Invalid channel on the two-channel instance.
    p0 = hi2;
    @(negedge clk);
    v2 = 1'b1; c2 = 2'd2; d2 = 1'b1; s2 = 8'd5;
    n = 0;
    while (ready2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready2", ready2, 1);
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("inv_done_next", done2, 1);
    chk("inv_err", err2, 1);
    chk("inv_busy", busy2, 1);
    @(posedge clk); #1;
    chk("inv_done_cleared", done2, 0);
    chk("inv_err_cleared", err2, 0);
    chk("inv_no_pulse", hi2 - p0, 0);
    chk("inv_pos_unchanged", pos2, 0);

    for (int k = 0; k < 16; k++) begin
      rc = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      rs = 8'($urandom_range(0, 7));
      present(rc, rd, rs);
      finish(rc, rd, rs);
    end

    // Lock drop during the second of three pulses.
    exp_sel = 2'd2;
    p0 = pulses;
    present(2'd2, 1'b1, 8'd3);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (!(pstep === 1'b1 && pulses == p0 + 1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("second_pulse_seen", pstep, 1);
    #2 lock = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("lockloss_pulses", pulses - p0, 2);
    chk("lockloss_busy", busy, 1);
    chk("lockloss_held_low", pstep, 0);
    chk("lockloss_width", badw, 0);
    @(negedge clk) lock = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lockloss_done", done, 1);
    chk("lockloss_total_pulses", pulses - p0, 3);
    mpos[2] = wrap_add(mpos[2], 3);
    chk("lockloss_pos", pos, model_vec());

    // Asynchronous reset in the middle of a pulse.
    present(2'd1, 1'b0, 8'd2);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (pstep !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pulse_before_reset", pstep, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phasestep", pstep, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ready, 0);
    chk("arst_done", done, 0);
    chk("arst_phasesel", psel, 0);
    chk("arst_phasedir", pdir, 0);
    chk("arst_pos", pos, 0);
    chk("arst_lsync", lsync, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
